// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared eXtension-interface sizing: register data width and coprocessor instruction id width.
package cv32e40px_core_v_xif_pkg;

  localparam int XLEN       = 32;
  localparam int X_ID_WIDTH = 4;

endpackage

// File: rtl/cv32e40px_x_result_fifo.sv
// Circular result store with registered pointers/count; storage itself is never reset.
module cv32e40px_x_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cv32e40px_x_result_buf.sv
// Buffers coprocessor results and retires them in order into the regfile write port
// whenever the core pipeline leaves it free, clearing the matching scoreboard bit.
module cv32e40px_x_result_buf
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = cv32e40px_core_v_xif_pkg::XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] x_result_id_i,
  input  logic [XLEN-1:0]       x_result_data_i,
  input  logic [4:0]            x_result_rd_i,
  input  logic                  x_result_we_i,
  input  logic                  wb_port_busy_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  sb_clr_valid_o,
  output logic [4:0]            sb_clr_addr_o,
  output logic [X_ID_WIDTH-1:0] last_id_o,
  output logic                  empty_o
);

  localparam int ENTRY_W = X_ID_WIDTH + 5 + XLEN;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [X_ID_WIDTH-1:0] head_id;
  logic [4:0]            head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  enqueue;
  logic                  retire;
  logic [X_ID_WIDTH-1:0] last_id_q;

  // Ready depends on occupancy alone, so a full buffer never passes a result through.
  assign x_result_ready_o = (fifo_count != CNT_W'(DEPTH));
  assign accept           = x_result_valid_i & x_result_ready_o;
  assign enqueue          = accept & x_result_we_i & (x_result_rd_i != 5'd0) & ~fifo_full;
  assign push_entry       = {x_result_id_i, x_result_rd_i, x_result_data_i};

  assign {head_id, head_rd, head_data} = head_entry;

  cv32e40px_x_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (enqueue),
    .data_i  (push_entry),
    .pop_i   (retire),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head retires on the same edge it is written; the core always has port priority.
  assign retire         = ~fifo_empty & ~wb_port_busy_i;
  assign rf_we_o        = retire;
  assign rf_waddr_o     = retire ? head_rd   : 5'd0;
  assign rf_wdata_o     = retire ? head_data : '0;
  assign sb_clr_valid_o = retire;
  assign sb_clr_addr_o  = retire ? head_rd   : 5'd0;
  assign empty_o        = fifo_empty;
  assign last_id_o      = last_id_q;

  // A non-writing result is accepted after anything still queued, so it is the newer id.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_id_q <= '0;
    end else if (accept && !enqueue) begin
      last_id_q <= x_result_id_i;
    end else if (retire) begin
      last_id_q <= head_id;
    end
  end

endmodule

// File: doc/cv32e40px_x_result_buf.md
CV32E40PX_X_RESULT_BUF -- requirements
Module: cv32e40px_x_result_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered result entries (power of two, >= 2).
REQ-002 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-003 SHALL have port clk_i  input  1  core clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port x_result_valid_i  input  1  coprocessor result valid.
REQ-006 SHALL have port x_result_ready_o  output  1  buffer accepts a result.
REQ-007 SHALL have port x_result_id_i  input  4  instruction id of the result.
REQ-008 SHALL have port x_result_data_i  input  XLEN  result data.
REQ-009 SHALL have port x_result_rd_i  input  5  destination register.
REQ-010 SHALL have port x_result_we_i  input  1  result requests a register write.
REQ-011 SHALL have port wb_port_busy_i  input  1  core pipeline uses the regfile write port this cycle.
REQ-012 SHALL have port rf_we_o  output  1  regfile write enable.
REQ-013 SHALL have port rf_waddr_o  output  5  regfile write address.
REQ-014 SHALL have port rf_wdata_o  output  XLEN  regfile write data.
REQ-015 SHALL have port sb_clr_valid_o  output  1  one-cycle pulse: clear scoreboard bit.
REQ-016 SHALL have port sb_clr_addr_o  output  5  register whose scoreboard bit is cleared.
REQ-017 SHALL have port last_id_o  output  4  id of the most recently retired result.
REQ-018 SHALL have port empty_o  output  1  no result pending (fence/debug drain).

Function
- REQ-019 SHALL accept a result on x_result_valid_i & x_result_ready_o (handshake); data SHALL NOT be sampled otherwise.
- REQ-020 SHALL drive x_result_ready_o = ~full, combinationally from count only; no pass-through when full, even if a pop occurs the same cycle.
- REQ-021 SHALL enqueue {id, rd, data} only when x_result_we_i=1 and rd!=0; other accepted results SHALL NOT be enqueued, SHALL update last_id_o next cycle, and SHALL NOT produce a write or scoreboard pulse.
- REQ-022 SHALL have a fixed latency of 1 cycle: an entry enqueued at edge N SHALL be first presented at the head at cycle N+1; there is no combinational input-to-rf path.
- REQ-023 SHALL assert rf_we_o = ~empty & ~wb_port_busy_i, with rf_waddr_o/rf_wdata_o taken from the head entry; the head SHALL be popped on the same edge.
- REQ-024 SHALL hold the head unchanged and keep rf_we_o=0 while wb_port_busy_i=1; there is no timeout.
- REQ-025 SHALL pulse sb_clr_valid_o with sb_clr_addr_o=head rd in exactly the cycle rf_we_o=1.
- REQ-026 SHALL update last_id_o on the edge following a pop to the popped entry's id, or per REQ-021.
- REQ-027 SHALL handle a simultaneous push and pop (not full) with count unchanged and both pointers advanced.
- REQ-028 SHALL make pointers log2(DEPTH) bits wide with natural wrap-around; count SHALL be log2(DEPTH)+1 bits; full is count==DEPTH, empty is count==0.
- REQ-029 SHALL preserve ordering: writes SHALL retire strictly in acceptance order.
- REQ-030 SHALL drive rf_waddr_o/rf_wdata_o to 0 when rf_we_o=0.

Reset
- REQ-031 SHALL, on rst_ni=0, asynchronously clear pointers, count and last_id_o to 0; storage SHALL NOT be reset.
- REQ-032 SHALL hold these values in reset: empty_o=1, x_result_ready_o=1, rf_we_o=0, sb_clr_valid_o=0, last_id_o=0.
- REQ-033 SHALL discard all pending entries on a reset asserted mid-operation; no write SHALL occur in the reset cycle.

Structure
- REQ-034 SHALL take XLEN and X_ID_WIDTH (4) from cv32e40px_core_v_xif_pkg; no new package types are required.
- REQ-035 SHALL implement storage as one sub-module, cv32e40px_x_result_fifo (parameterised DEPTH/width, push/pop/full/empty/count); arbitration and last_id tracking SHALL stay in the top.

Verification
- REQ-036 Bench SHALL cover: single result id=3, rd=5, data=0xDEADBEEF, port free -> rf_we_o=1 one cycle later, waddr=5, sb_clr pulse addr 5, last_id_o=3 the following cycle.
- REQ-037 Bench SHALL cover: 4 back-to-back results with wb_port_busy_i=1 held -> ready_o=0 after the 4th; 5th valid held off; release busy -> 4 writes in order, one per cycle, then the 5th is accepted.
- REQ-038 Bench SHALL cover: result with rd=0 or we=0 -> no rf_we_o, no sb_clr pulse, empty_o stays 1, last_id_o updated.
- REQ-039 Bench SHALL cover: full buffer with push and pop requested the same cycle -> push rejected (ready_o=0), count drops to 3.
- REQ-040 Bench SHALL cover: busy toggling every cycle with continuous pushes -> no loss, order preserved, pointers wrap twice.
- REQ-041 Bench SHALL cover: rst_ni asserted with 2 entries pending -> immediately empty_o=1, no write issued after release.
